// File: rtl/delta_sampler_if.sv
// Result channel of delta_sampler: valid/ready handshake carrying the
// accumulated delta and its status flags.
interface delta_sampler_if #(
  parameter int unsigned OUT_WIDTH = 6
);
  logic                 valid;
  logic                 ready;
  logic [OUT_WIDTH-1:0] delta;
  logic                 wrap;
  logic                 coalesced;
  logic                 sat;

  modport master (
    output valid,
    output delta,
    output wrap,
    output coalesced,
    output sat,
    input  ready
  );

  modport slave (
    input  valid,
    input  delta,
    input  wrap,
    input  coalesced,
    input  sat,
    output ready
  );
endinterface

// File: rtl/delta_sampler.sv
// Samples a free-running counter on request and emits the modular difference
// since the previous sample; back-pressured intervals are merged with saturation.
module delta_sampler #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned OUT_WIDTH = WIDTH + 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             down_i,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] count_i,
  delta_sampler_if.master  res
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     base_q;
  logic                 valid_q;
  logic [OUT_WIDTH-1:0] delta_q;
  logic                 wrap_q;
  logic                 coalesced_q;
  logic                 sat_q;

  logic [WIDTH-1:0]     intv_delta;
  logic                 intv_wrap;
  logic [OUT_WIDTH:0]   acc_sum;
  logic                 acc_ovf;
  logic [OUT_WIDTH-1:0] acc_val;

  // Interval difference/wrap against the baseline, and the guarded coalescing sum.
  always_comb begin
    intv_delta = '0;
    intv_wrap  = 1'b0;
    if (down_i) begin
      intv_delta = base_q - count_i;
      intv_wrap  = (count_i > base_q);
    end else begin
      intv_delta = count_i - base_q;
      intv_wrap  = (count_i < base_q);
    end
    acc_sum = {1'b0, delta_q} + (OUT_WIDTH + 1)'(intv_delta);
    acc_ovf = acc_sum[OUT_WIDTH];
    if (acc_ovf) begin
      acc_val = '1;
    end else begin
      acc_val = acc_sum[OUT_WIDTH-1:0];
    end
  end

  // Sampler FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      base_q      <= '0;
      valid_q     <= 1'b0;
      delta_q     <= '0;
      wrap_q      <= 1'b0;
      coalesced_q <= 1'b0;
      sat_q       <= 1'b0;
    end else if (clear_i) begin
      // Clear wins over any same-cycle sample or handshake.
      state_q     <= EMPTY;
      base_q      <= '0;
      valid_q     <= 1'b0;
      delta_q     <= '0;
      wrap_q      <= 1'b0;
      coalesced_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (sample_i) begin
            base_q  <= count_i;
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (sample_i) begin
            base_q      <= count_i;
            valid_q     <= 1'b1;
            delta_q     <= OUT_WIDTH'(intv_delta);
            wrap_q      <= intv_wrap;
            coalesced_q <= 1'b0;
            sat_q       <= 1'b0;
            state_q     <= PENDING;
          end
        end
        PENDING: begin
          if (sample_i) begin
            base_q <= count_i;
            if (res.ready) begin
              // Held result leaves this cycle; the new interval starts fresh.
              delta_q     <= OUT_WIDTH'(intv_delta);
              wrap_q      <= intv_wrap;
              coalesced_q <= 1'b0;
              sat_q       <= 1'b0;
            end else begin
              delta_q     <= acc_val;
              wrap_q      <= wrap_q | intv_wrap;
              coalesced_q <= 1'b1;
              sat_q       <= sat_q | acc_ovf;
            end
          end else if (res.ready) begin
            valid_q <= 1'b0;
            state_q <= ARMED;
          end
        end
        default: begin
          state_q     <= EMPTY;
          base_q      <= '0;
          valid_q     <= 1'b0;
          delta_q     <= '0;
          wrap_q      <= 1'b0;
          coalesced_q <= 1'b0;
          sat_q       <= 1'b0;
        end
      endcase
    end
  end

  assign res.valid     = valid_q;
  assign res.delta     = delta_q;
  assign res.wrap      = wrap_q;
  assign res.coalesced = coalesced_q;
  assign res.sat       = sat_q;

endmodule

// File: tb/tb_delta_sampler.sv
// Table-driven bench for delta_sampler (WIDTH=4, OUT_WIDTH=6) plus hand-written
// reset sequences.
module tb_delta_sampler;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       clear_i;
  logic       down_i;
  logic       sample_i;
  logic [3:0] count_i;

  delta_sampler_if #(.OUT_WIDTH(6)) res_if ();

  delta_sampler #(.WIDTH(4), .OUT_WIDTH(6)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .down_i   (down_i),
    .sample_i (sample_i),
    .count_i  (count_i),
    .res      (res_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       clr, dn, smp, rdy;
    logic [3:0] cnt;
    logic       x, v, chk;
    logic [5:0] dl;
    logic       w, c, s;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic clr, logic dn, logic smp, logic rdy, logic [3:0] cnt,
                              logic x, logic v, logic chk, logic [5:0] dl,
                              logic w, logic c, logic s);
    vec_t r;
    r.clr = clr; r.dn = dn; r.smp = smp; r.rdy = rdy; r.cnt = cnt;
    r.x = x; r.v = v; r.chk = chk; r.dl = dl; r.w = w; r.c = c; r.s = s;
    return r;
  endfunction

  task automatic check_outs(string name, logic v, logic [5:0] dl, logic w, logic c, logic s);
    tests++;
    if (res_if.valid !== v || res_if.delta !== dl || res_if.wrap !== w ||
        res_if.coalesced !== c || res_if.sat !== s) begin
      fails++;
      $display("FAIL %s: got v=%0b d=%0d w=%0b c=%0b s=%0b, need v=%0b d=%0d w=%0b c=%0b s=%0b",
               name, res_if.valid, res_if.delta, res_if.wrap, res_if.coalesced, res_if.sat,
               v, dl, w, c, s);
    end
  endtask

  initial begin
    logic hs;
    logic ok;

    // Baseline then wrap (up), equal samples, down-counting.
    vecs[0]  = mk(0,0,1,1, 4'd3,  0,0,0, 6'd0, 0,0,0);
    vecs[1]  = mk(0,0,1,1, 4'd7,  0,1,1, 6'd4, 0,0,0);
    vecs[2]  = mk(0,0,0,1, 4'd0,  1,0,0, 6'd0, 0,0,0);
    vecs[3]  = mk(0,0,1,1, 4'd14, 0,1,1, 6'd7, 0,0,0);
    vecs[4]  = mk(0,0,1,1, 4'd2,  1,1,1, 6'd4, 1,0,0);
    vecs[5]  = mk(0,0,1,1, 4'd5,  1,1,1, 6'd3, 0,0,0);
    vecs[6]  = mk(0,0,1,1, 4'd5,  1,1,1, 6'd0, 0,0,0);
    vecs[7]  = mk(0,0,0,1, 4'd0,  1,0,0, 6'd0, 0,0,0);
    vecs[8]  = mk(0,1,1,1, 4'd1,  0,1,1, 6'd4, 0,0,0);
    vecs[9]  = mk(0,1,1,1, 4'd13, 1,1,1, 6'd4, 1,0,0);
    // Clear while pending, then back-pressure with coalescing and saturation.
    vecs[10] = mk(1,0,0,1, 4'd0,  0,0,1, 6'd0, 0,0,0);
    vecs[11] = mk(0,0,1,0, 4'd0,  0,0,0, 6'd0, 0,0,0);
    vecs[12] = mk(0,0,1,0, 4'd10, 0,1,1, 6'd10, 0,0,0);
    vecs[13] = mk(0,0,1,0, 4'd5,  0,1,1, 6'd21, 1,1,0);
    vecs[14] = mk(0,0,1,0, 4'd4,  0,1,1, 6'd36, 1,1,0);
    vecs[15] = mk(0,0,1,0, 4'd3,  0,1,1, 6'd51, 1,1,0);
    vecs[16] = mk(0,0,1,0, 4'd2,  0,1,1, 6'd63, 1,1,1);
    vecs[17] = mk(0,0,0,0, 4'd0,  0,1,1, 6'd63, 1,1,1);
    vecs[18] = mk(0,0,0,1, 4'd0,  1,0,0, 6'd0, 0,0,0);
    vecs[19] = mk(0,0,0,1, 4'd0,  0,0,0, 6'd0, 0,0,0);
    // Sample and accept in the same cycle.
    vecs[20] = mk(0,0,1,0, 4'd5,  0,1,1, 6'd3, 0,0,0);
    vecs[21] = mk(0,0,1,1, 4'd7,  1,1,1, 6'd2, 0,0,0);
    vecs[22] = mk(0,0,0,1, 4'd0,  1,0,0, 6'd0, 0,0,0);
    // Clear beats a simultaneous sample and handshake; next sample only rebaselines.
    vecs[23] = mk(0,0,1,0, 4'd9,  0,1,1, 6'd2, 0,0,0);
    vecs[24] = mk(1,0,1,1, 4'd12, 0,0,1, 6'd0, 0,0,0);
    vecs[25] = mk(0,0,1,0, 4'd15, 0,0,0, 6'd0, 0,0,0);
    vecs[26] = mk(0,0,1,0, 4'd1,  0,1,1, 6'd2, 1,0,0);
    vecs[27] = mk(0,0,0,1, 4'd0,  1,0,0, 6'd0, 0,0,0);

    rst_ni = 1'b0; clear_i = 1'b0; down_i = 1'b0; sample_i = 1'b0;
    count_i = 4'd0; res_if.ready = 1'b1;
    #12;
    check_outs("reset", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      clear_i = vecs[i].clr; down_i = vecs[i].dn; sample_i = vecs[i].smp;
      res_if.ready = vecs[i].rdy; count_i = vecs[i].cnt;
      #1;
      hs = res_if.valid & res_if.ready & ~clear_i;
      @(posedge clk_i);
      #1;
      ok = (hs === vecs[i].x) && (res_if.valid === vecs[i].v) &&
           (!vecs[i].chk || (res_if.delta === vecs[i].dl && res_if.wrap === vecs[i].w &&
                             res_if.coalesced === vecs[i].c && res_if.sat === vecs[i].s));
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL vec%0d: got xfer=%0b v=%0b d=%0d w=%0b c=%0b s=%0b, need xfer=%0b v=%0b d=%0d w=%0b c=%0b s=%0b (data checked=%0b)",
                 i, hs, res_if.valid, res_if.delta, res_if.wrap, res_if.coalesced, res_if.sat,
                 vecs[i].x, vecs[i].v, vecs[i].dl, vecs[i].w, vecs[i].c, vecs[i].s, vecs[i].chk);
      end
    end

    // Asynchronous reset while a result is pending.
    @(negedge clk_i);
    clear_i = 1'b0; down_i = 1'b0; sample_i = 1'b1; count_i = 4'd3; res_if.ready = 1'b0;
    @(posedge clk_i);
    #1;
    check_outs("pending_before_reset", 1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
    sample_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1; sample_i = 1'b1; count_i = 4'd8; res_if.ready = 1'b1;
    @(posedge clk_i);
    #1;
    check_outs("rebaseline_after_reset", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    count_i = 4'd9; res_if.ready = 1'b0;
    @(posedge clk_i);
    #1;
    check_outs("first_after_reset", 1'b1, 6'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    sample_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delta_sampler.md
# delta_sampler

Reader-side companion of the variable-delta up/down counter. It samples a free-running counter value on request and emits the modular difference since the previous sample over a valid/ready interface, flagging wrap-around. When the consumer back-pressures, deltas are coalesced with saturation. It sits between the counter bank and the performance/rate-monitoring logic that consumes per-interval increments.

## Interface
- WIDTH, 4: width of the sampled counter value.
- OUT_WIDTH, WIDTH+2: width of the emitted delta accumulator; must be >= WIDTH.
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous clear: drops the baseline and any pending output.
- down_i  input  1  counter direction: 0 = up-counting, 1 = down-counting; sampled with sample_i.
- sample_i  input  1  single-cycle sample request.
- count_i  input  WIDTH  current counter value.
- valid_o  output  1  delta_o/wrap_o/coalesced_o/sat_o hold a result.
- ready_i  input  1  consumer accepts the result when valid_o && ready_i.
- delta_o  output  OUT_WIDTH  accumulated count difference.
- wrap_o  output  1  at least one included interval wrapped modulo 2^WIDTH.
- coalesced_o  output  1  result merges two or more intervals.
- sat_o  output  1  accumulation clamped at 2^OUT_WIDTH-1.

## Operation
- States: EMPTY (no baseline), ARMED (baseline held, no pending output), PENDING (baseline held, valid_o=1).
- EMPTY: sample_i stores count_i as the baseline and moves to ARMED. No output is produced.
- Interval delta d (WIDTH bits, mod 2^WIDTH): d = count_i - base when down_i=0, and d = base - count_i when down_i=1.
- Interval wrap w: count_i < base when up-counting; count_i > base when down-counting. Equal values give d=0, w=0.
- On every sample in ARMED or PENDING, the baseline is updated to count_i.
- ARMED + sample_i: load delta_o = zero-extended d, wrap_o = w, coalesced_o = 0, sat_o = 0; go to PENDING.
- PENDING + ready_i, no sample_i: result is consumed; go to ARMED.
- PENDING + sample_i + ready_i: the held result is consumed, then a fresh result is loaded as in ARMED; stay in PENDING.
- PENDING + sample_i + !ready_i: coalesce.
  - delta_o = min(delta_o + d, 2^OUT_WIDTH-1), computed with one guard bit.
  - sat_o |= (sum overflowed).
  - wrap_o |= w.
  - coalesced_o = 1.
- Output registers are stable while valid_o && !ready_i, except when coalescing.
- clear_i has highest priority over sample_i and ready_i. It forces EMPTY, valid_o=0, and zeroes all outputs; a handshake in the same cycle does not count as a transfer.
- Multiple wraps within one interval are undetectable; sampling rate is the user's responsibility.

## Timing
- Reset values: state EMPTY; valid_o=0; delta_o=0; wrap_o=0; coalesced_o=0; sat_o=0; baseline=0.
- Latency: sample_i at edge t produces a result visible after edge t, i.e. valid_o is high in cycle t+1.
- Throughput: one sample per cycle, with ready_i held high, gives one result per cycle.
- valid_o never depends combinationally on ready_i. All outputs are registered.
- Reset asserted mid-operation discards the baseline and any pending result immediately (asynchronous reset).

## Test plan
- Baseline: WIDTH=4, OUT_WIDTH=6, ready_i=1. Sample count_i=3, then count_i=7 -> valid_o only after the second sample; delta_o=4, wrap_o=0, coalesced_o=0.
- Wrap, up-counting: baseline 14, then sample 2 -> delta_o=4, wrap_o=1. Equal samples 5,5 -> delta_o=0, wrap_o=0.
- Down-counting: down_i=1. Baseline 5, sample 1 -> delta_o=4, wrap_o=0. Next sample 13 -> delta_o=4, wrap_o=1.
- Back-pressure: ready_i=0. Samples 0, 10, 5 -> delta_o=10, then 21 with coalesced_o=1 and wrap_o=1. Further samples 4, 3 (+15 each, wrapping) -> delta_o=36, then 51; one more sample 2 (+15) -> delta_o=63, sat_o=1. Raising ready_i -> one transfer, then valid_o=0.
- Simultaneous: PENDING with delta_o=3; sample_i (d=2) and ready_i=1 in the same cycle -> the 3 is accepted; next result delta_o=2, coalesced_o=0, valid_o stays 1.
- Clear/reset: clear_i together with sample_i and ready_i in PENDING -> valid_o=0 next cycle, no transfer counted, next sample only rebaselines. Asserting rst_ni low mid-PENDING -> all outputs 0 immediately.
